// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the elastic inter-stage registers of the pipelined CPU.
//   pipe_state_e : occupancy state of a pipe_stage_reg instance
//   *_t structs  : per-boundary payload bundles. Stage instances pack these
//                  into the opaque data_i bus and unpack data_o. The stage
//                  register never looks inside them.
//   EX_MEM_W     : width of the EX/MEM bundle, the default stage payload.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // EMPTY : nothing held, ready for input
  // FULL  : main register holds a valid word
  // SKID  : main and skid both hold words; upstream is being back-pressured
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_e;

  // IF/ID boundary
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } if_id_t;

  // ID/EX boundary
  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] immext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } id_ex_t;

  // EX/MEM boundary
  typedef struct packed {
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
  } ex_mem_t;

  // MEM/WB boundary
  typedef struct packed {
    logic [31:0] aluresult;
    logic [31:0] readdata;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
  } mem_wb_t;

  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping, so a long
// stall never reads back as a short one.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset, clears the count
//   inc_i : count this cycle
//   cnt_o : current count, W bits, saturates at 2^W-1
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == {W{1'b1}});

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic pipeline stage register with valid/ready handshaking. It carries an
// opaque DATA_W-bit payload, supports a synchronous flush for hazard bubbles,
// and optionally adds a skid entry so that ready_o comes straight from a flop.
//
// Parameters
//   DATA_W       : payload width (default fits the EX/MEM bundle)
//   SKID_EN      : 1 = main + skid entry, registered ready_o
//                  0 = main only, ready_o = !valid_o || ready_i
//   CLR_ON_FLUSH : 1 = payload registers zeroed on flush, 0 = payload kept
//   CNT_W        : stall counter width
//
// Ports
//   clk_i       in   clock, rising edge
//   rst_i       in   asynchronous active-low reset
//   flush_i     in   synchronous flush, overrides every handshake this cycle
//   valid_i     in   upstream word valid
//   ready_o     out  stage accepts; transfer when valid_i && ready_o
//   data_i      in   upstream payload
//   valid_o     out  downstream word valid
//   ready_i     in   downstream accepts; transfer when valid_o && ready_i
//   data_o      out  downstream payload (main register)
//   stall_cnt_o out  saturating count of cycles with valid_o && !ready_i
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W       = EX_MEM_W,
  parameter bit          SKID_EN      = 1'b1,
  parameter bit          CLR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_next;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;

  logic w_main_ld_in;    // main <= data_i
  logic w_main_ld_skid;  // main <= skid (drain skid entry)
  logic w_skid_ld;       // skid <= data_i (capture on stall)
  logic w_clr;           // zero both payload registers
  logic w_stall;

  // ---------------------------------------------------------------------------
  // Next-state and load decode. The FSM only loads from data_i in states where
  // ready_o is high, so acceptance and the loads below always agree.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    w_clr          = 1'b0;

    unique case (r_state)
      PS_EMPTY: begin
        if (valid_i) begin
          w_main_ld_in = 1'b1;
          w_state_next = PS_FULL;
        end
      end
      PS_FULL: begin
        if (ready_i) begin
          if (valid_i) begin
            // Downstream takes the current word while a new one arrives.
            w_main_ld_in = 1'b1;
          end else begin
            w_state_next = PS_EMPTY;
          end
        end else if (valid_i && SKID_EN) begin
          // ready_o was already high this cycle, so the offered word must be
          // caught somewhere: park it in the skid entry.
          w_skid_ld    = 1'b1;
          w_state_next = PS_SKID;
        end
      end
      PS_SKID: begin
        if (ready_i) begin
          w_main_ld_skid = 1'b1;
          w_state_next   = PS_FULL;
        end
      end
      default: begin
        w_state_next = PS_EMPTY;
      end
    endcase

    // Flush drops the held words and anything offered this cycle.
    if (flush_i) begin
      w_state_next   = PS_EMPTY;
      w_main_ld_in   = 1'b0;
      w_main_ld_skid = 1'b0;
      w_skid_ld      = 1'b0;
      w_clr          = CLR_ON_FLUSH;
    end
  end

  // ---------------------------------------------------------------------------
  // State and payload registers. The skid entry is valid exactly when the
  // state is PS_SKID, so no separate valid flop is kept for it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= PS_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_clr) begin
        r_main <= '0;
        r_skid <= '0;
      end else begin
        if (w_main_ld_in) begin
          r_main <= data_i;
        end else if (w_main_ld_skid) begin
          r_main <= r_skid;
        end
        if (w_skid_ld) begin
          r_skid <= data_i;
        end
      end
    end
  end

  assign valid_o = (r_state != PS_EMPTY);
  assign data_o  = r_main;

  // ---------------------------------------------------------------------------
  // Upstream ready.
  // ---------------------------------------------------------------------------
  generate
    if (SKID_EN) begin : g_skid_ready
      // Flopped from the next state so ready_o has no path from ready_i.
      logic r_ready;

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          r_ready <= 1'b1;
        end else begin
          r_ready <= (w_state_next != PS_SKID);
        end
      end

      assign ready_o = r_ready;
    end else begin : g_comb_ready
      // Without a skid entry the stage can only accept when the main word
      // leaves in the same cycle, which needs ready_i combinationally.
      assign ready_o = !valid_o || ready_i;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stall counter, cleared only by reset (flush leaves it alone).
  // ---------------------------------------------------------------------------
  assign w_stall = valid_o && !ready_i;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall),
    .cnt_o (stall_cnt_o)
  );

endmodule : pipe_stage_reg

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register replacing the fixed-field inter-stage registers of the pipelined CPU (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque DATA_W-bit payload with valid/ready handshaking, synchronous flush for hazard bubbles, and an optional skid buffer so ready_o is fully registered. A saturating stall counter supports performance analysis.

## Interface
- DATA_W, 101, payload width; default fits the EX/MEM bundle: aluresult 32 + writedata 32 + rd 5 + pcplus4 32.
- SKID_EN, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single register with combinational ready_o.
- CLR_ON_FLUSH, 1, 1 = payload registers cleared to 0 on flush; 0 = payload holds, only valid drops.
- CNT_W, 16, stall counter width.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush, highest priority below reset.
- valid_i  in  1  upstream payload valid.
- ready_o  out  1  stage can accept; transfer when valid_i && ready_o.
- data_i  in  DATA_W  upstream payload.
- valid_o  out  1  downstream payload valid.
- ready_i  in  1  downstream accepts; transfer when valid_o && ready_i.
- data_o  out  DATA_W  downstream payload (main register).
- stall_cnt_o  out  CNT_W  cycles with valid_o && !ready_i, saturating.

## Operation
- Reset values: valid_o 0, data_o 0, stall_cnt_o 0, skid register 0 and invalid, state EMPTY, ready_o 1.
- SKID_EN=1, states EMPTY / FULL / SKID; ready_o = (state != SKID), registered.
- EMPTY: valid_i -> main <= data_i, go FULL; else stay.
- FULL: valid_i && ready_i -> main <= data_i, stay FULL. !valid_i && ready_i -> EMPTY. valid_i && !ready_i -> skid <= data_i, go SKID. Neither -> stay.
- SKID: ready_i -> main <= skid, go FULL; input not accepted (ready_o 0). !ready_i -> stay.
- SKID_EN=0, states EMPTY / FULL only; ready_o = !valid_o || ready_i (combinational); FULL with ready_i && valid_i reloads main.
- flush_i: next state EMPTY, valid_o and skid valid cleared, any input offered that cycle dropped even if ready_o was 1; if CLR_ON_FLUSH=1, main and skid payload <= 0. Flush overrides every transition above.
- Stall counter: +1 each cycle valid_o && !ready_i, holds at 2^CNT_W-1; flush does not clear it; only rst_i clears.
- Payload order preserved strictly; no payload duplicated or lost except by flush.

## Timing
- Latency: data accepted on edge N appears on data_o with valid_o after edge N (1 cycle).
- Throughput: 1 transfer/cycle sustained with ready_i high, both SKID_EN modes.
- SKID_EN=1: after a stall capture, ready_o low from the next cycle until the cycle after ready_i returns; no combinational path ready_i -> ready_o.
- Reset asserted mid-transfer: all state cleared immediately (asynchronous); release synchronous to clk_i, first acceptance on the first edge after release.
- Simultaneous flush_i and ready_i in SKID: flush wins, skid entry discarded, next state EMPTY.

## Structure
- Shared package pipe_pkg: pipe_state_e enum {PS_EMPTY, PS_FULL, PS_SKID}; ex_mem_t packed struct (aluresult, writedata, rd, pcplus4) and localparam EX_MEM_W = $bits(ex_mem_t); equivalent structs for other stages added there.
- One sub-module: sat_counter (parameter W, inputs clk_i, rst_i, inc_i, output cnt_o) for the stall counter.
- Stage instances pack/unpack their struct at the port; this block never interprets payload fields.

## Test plan
- Reset: drive rst_i low mid-stream with valid_i=1 -> valid_o 0, data_o 0, stall_cnt_o 0, ready_o 1 immediately; first word after release appears one cycle later.
- Streaming: ready_i=1, send 0x1..0x8 back-to-back -> data_o 0x1..0x8 on consecutive cycles, valid_o continuous, stall_cnt_o 0.
- Backpressure (SKID_EN=1): send A,B,C; drop ready_i for 3 cycles while B offered -> B held in skid, ready_o 0, C not accepted; ready_i high -> outputs A,B,C in order, stall_cnt_o = 3.
- Flush: in SKID state with ready_i=1 assert flush_i -> next cycle valid_o 0, state EMPTY, data_o 0 (CLR_ON_FLUSH=1) or unchanged (CLR_ON_FLUSH=0).
- Saturation: CNT_W=4, hold valid_o with ready_i=0 for 20 cycles -> stall_cnt_o stops at 15.
- SKID_EN=0: ready_i=0 with valid_o=1 -> ready_o 0 same cycle; ready_i=1 with valid_i=1 -> new word on data_o next cycle, no bubble.
